bus_arbiter: RTL

- Shares one 8-bit-data / 10-bit-address memory port among NUM_CORES core instances, using the per-core grant_request / grant_given handshake.
- One transaction per grant. Round-robin priority. A multi-cycle memory access is completed through the memory's mem_ready handshake.
- Sits between the core array and the unified instruction/data memory.

---
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one 8-bit data / 10-bit address memory port among NUM_CORES cores.
// Ports: clk, reset (async active-low); grant_request/req_rw/req_addr/req_wdata per-core requests (packed by core);
//        grant_given one-hot completion pulse, rdata broadcast read data; mem_req/mem_rw/mem_addr/mem_wdata to memory,
//        mem_rdata/mem_ready from memory; owner = core being served; busy = ACCESS or GRANT.
// Optional: define ARB_TIMEOUT_EN to add a mem_ready timeout and the sticky bus_error output.
module bus_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int IDX_W          = $clog2(NUM_CORES),
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CORES-1:0]    grant_request,
   input  logic [NUM_CORES-1:0]    req_rw,
   input  logic [NUM_CORES*10-1:0] req_addr,
   input  logic [NUM_CORES*8-1:0]  req_wdata,
   output logic [NUM_CORES-1:0]    grant_given,
   output logic [7:0]              rdata,
   output logic                    mem_req,
   output logic                    mem_rw,
   output logic [9:0]              mem_addr,
   output logic [7:0]              mem_wdata,
   input  logic [7:0]              mem_rdata,
   input  logic                    mem_ready,
   output logic [IDX_W-1:0]        owner,
   output logic                    busy
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                    bus_error
`endif
);
   typedef enum logic [1:0] {IDLE, ACCESS, GRANT} state_t;
   localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);
   state_t state, state_nxt;
   logic [IDX_W-1:0] rr_last, rr_nxt, owner_nxt, sel, idx;
   logic [NUM_CORES-1:0] gnt_nxt;
   logic [7:0] rdata_nxt, wdata_nxt;
   logic [9:0] addr_nxt;
   logic found, done, req_nxt, rw_nxt, busy_nxt;
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt, cnt_nxt;
   logic err_nxt, expired;
   assign expired = !mem_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
   assign done = mem_ready || expired;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign done = mem_ready;
`endif
   // Cyclic search from rr_last+1: scanning the farthest candidate first lets the nearest one win.
   always_comb begin
      sel = '0;
      idx = '0;
      found = 1'b0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         idx = IDX_W'((int'(rr_last) + k) % NUM_CORES);
         if (grant_request[idx]) begin
            sel = idx;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_last;
      owner_nxt = owner;
      gnt_nxt   = grant_given;
      rdata_nxt = rdata;
      req_nxt   = mem_req;
      rw_nxt    = mem_rw;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      busy_nxt  = busy;
`ifdef ARB_TIMEOUT_EN
      cnt_nxt   = cnt;
      err_nxt   = bus_error;
`endif
      case (state)
         IDLE: if (found) begin
            owner_nxt = sel;
            rw_nxt    = req_rw[sel];
            addr_nxt  = req_addr[sel*10 +: 10];
            wdata_nxt = req_wdata[sel*8 +: 8];
            req_nxt   = 1'b1;
            busy_nxt  = 1'b1;
            state_nxt = ACCESS;
`ifdef ARB_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
         end
         ACCESS: begin
`ifdef ARB_TIMEOUT_EN
            cnt_nxt = cnt + 1'b1;
            if (expired) begin
               rdata_nxt = 8'hFF;
               err_nxt   = 1'b1;
            end
`endif
            if (done) begin
               req_nxt   = 1'b0;
               rdata_nxt = (mem_ready && !mem_rw) ? mem_rdata : rdata_nxt;
               gnt_nxt   = ONE << owner;
               rr_nxt    = owner;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         rr_last     <= IDX_W'(NUM_CORES - 1);
         owner       <= '0;
         grant_given <= '0;
         rdata       <= '0;
         mem_req     <= 1'b0;
         mem_rw      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt         <= '0;
         bus_error   <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         rr_last     <= rr_nxt;
         owner       <= owner_nxt;
         grant_given <= gnt_nxt;
         rdata       <= rdata_nxt;
         mem_req     <= req_nxt;
         mem_rw      <= rw_nxt;
         mem_addr    <= addr_nxt;
         mem_wdata   <= wdata_nxt;
         busy        <= busy_nxt;
`ifdef ARB_TIMEOUT_EN
         cnt         <= cnt_nxt;
         bus_error   <= err_nxt;
`endif
      end
   end
endmodule
